// File: rtl/aurora_link_activity_monitor.sv
// Qualifies Aurora link status and stretches FIFO strobes into slow LED-friendly activity signals.
// Define AURORA_SOFT_ERR_COUNT_EN to build the saturating soft-error counter.
module aurora_link_activity_monitor #(
  parameter int LANES          = 1,
  parameter int QUAL_CYCLES    = 1024,
  parameter int STRETCH_CYCLES = 16,
  parameter int HOLD_CYCLES    = 4096,
  parameter int ERR_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             channel_up,
  input  logic [LANES-1:0] lane_up,
  input  logic             hard_err,
  input  logic             soft_err,
  input  logic             fifo_wr_en,
  input  logic             fifo_rd_en,
  input  logic             err_clr,
  output logic             rdy,
  output logic             wr_act,
  output logic             rd_act,
  output logic [1:0]       link_state,
  output logic [ERR_W-1:0] soft_err_cnt
);

  localparam int QW = $clog2(QUAL_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_LAST    = QW'(QUAL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

  typedef enum logic [1:0] {
    S_DOWN     = 2'b00,
    S_QUALIFY  = 2'b01,
    S_UP       = 2'b10,
    S_ERR_HOLD = 2'b11
  } state_t;

  state_t           state, state_nx;
  logic [QW-1:0]    qual_cnt, qual_cnt_nx;
  logic [HW-1:0]    hold_cnt, hold_cnt_nx;
  logic [SW-1:0]    wr_cnt, wr_cnt_nx, rd_cnt, rd_cnt_nx;
  logic             channel_up_m, channel_up_s;
  logic             hard_err_m, hard_err_s;
  logic             soft_err_m, soft_err_s;
  logic [LANES-1:0] lane_up_m, lane_up_s;
  logic             link_ok;

  // Two-flop synchronisers for everything coming from the Aurora clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      channel_up_m <= 1'b0;
      channel_up_s <= 1'b0;
      lane_up_m    <= '0;
      lane_up_s    <= '0;
      hard_err_m   <= 1'b0;
      hard_err_s   <= 1'b0;
      soft_err_m   <= 1'b0;
      soft_err_s   <= 1'b0;
    end else begin
      channel_up_m <= channel_up;
      channel_up_s <= channel_up_m;
      lane_up_m    <= lane_up;
      lane_up_s    <= lane_up_m;
      hard_err_m   <= hard_err;
      hard_err_s   <= hard_err_m;
      soft_err_m   <= soft_err;
      soft_err_s   <= soft_err_m;
    end
  end

  assign link_ok = channel_up_s & (&lane_up_s);

  always_comb begin
    state_nx    = state;
    qual_cnt_nx = qual_cnt;
    hold_cnt_nx = hold_cnt;
    case (state)
      S_DOWN: begin
        if (link_ok) begin
          state_nx    = S_QUALIFY;
          qual_cnt_nx = '0;
        end
      end
      S_QUALIFY: begin
        if (hard_err_s || !link_ok) state_nx = S_DOWN;
        else if (qual_cnt == QUAL_LAST) state_nx = S_UP;
        else qual_cnt_nx = qual_cnt + 1'b1;
      end
      S_UP: begin
        if (hard_err_s) begin
          state_nx    = S_ERR_HOLD;
          hold_cnt_nx = '0;
        end else if (!link_ok) begin
          state_nx = S_DOWN;
        end
      end
      S_ERR_HOLD: begin
        // A fresh hard error restarts the whole hold-off window.
        if (hard_err_s) hold_cnt_nx = '0;
        else if (hold_cnt == HOLD_LAST) state_nx = S_DOWN;
        else hold_cnt_nx = hold_cnt + 1'b1;
      end
      default: state_nx = S_DOWN;
    endcase
  end

  // Strobes only count while qualified; losing rdy clears any stretch in progress.
  always_comb begin
    wr_cnt_nx = wr_cnt;
    rd_cnt_nx = rd_cnt;
    if (!rdy) wr_cnt_nx = '0;
    else if (fifo_wr_en) wr_cnt_nx = STRETCH_LOAD;
    else if (wr_cnt != '0) wr_cnt_nx = wr_cnt - 1'b1;
    if (!rdy) rd_cnt_nx = '0;
    else if (fifo_rd_en) rd_cnt_nx = STRETCH_LOAD;
    else if (rd_cnt != '0) rd_cnt_nx = rd_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_DOWN;
      qual_cnt <= '0;
      hold_cnt <= '0;
      rdy      <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_act   <= 1'b0;
      rd_act   <= 1'b0;
    end else begin
      state    <= state_nx;
      qual_cnt <= qual_cnt_nx;
      hold_cnt <= hold_cnt_nx;
      rdy      <= (state_nx == S_UP);
      wr_cnt   <= wr_cnt_nx;
      rd_cnt   <= rd_cnt_nx;
      wr_act   <= (wr_cnt_nx != '0);
      rd_act   <= (rd_cnt_nx != '0);
    end
  end

  assign link_state = state;

`ifdef AURORA_SOFT_ERR_COUNT_EN
  logic soft_err_d;

  // Count rising edges of the synchronised soft error; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      soft_err_d   <= 1'b0;
      soft_err_cnt <= '0;
    end else begin
      soft_err_d <= soft_err_s;
      if (err_clr) soft_err_cnt <= '0;
      else if (soft_err_s && !soft_err_d && !(&soft_err_cnt)) soft_err_cnt <= soft_err_cnt + 1'b1;
    end
  end
`else
  logic unused_soft;
  assign unused_soft  = soft_err_s ^ err_clr;
  assign soft_err_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_link_activity_monitor.sv
// Self-checking bench for aurora_link_activity_monitor: vector table, directed corner sequences, random run.
module tb_aurora_link_activity_monitor;

  localparam int LANES   = 2;
  localparam int QUAL    = 8;
  localparam int STRETCH = 4;
  localparam int HOLD    = 16;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             channel_up = 1'b0;
  logic [LANES-1:0] lane_up = '0;
  logic             hard_err = 1'b0;
  logic             soft_err = 1'b0;
  logic             fifo_wr_en = 1'b0;
  logic             fifo_rd_en = 1'b0;
  logic             err_clr = 1'b0;
  logic             rdy, wr_act, rd_act;
  logic [1:0]       link_state;
  logic [ERR_W-1:0] soft_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  aurora_link_activity_monitor #(
    .LANES(LANES), .QUAL_CYCLES(QUAL), .STRETCH_CYCLES(STRETCH),
    .HOLD_CYCLES(HOLD), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .channel_up(channel_up), .lane_up(lane_up),
    .hard_err(hard_err), .soft_err(soft_err), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .err_clr(err_clr), .rdy(rdy), .wr_act(wr_act),
    .rd_act(rd_act), .link_state(link_state), .soft_err_cnt(soft_err_cnt)
  );

  always #15 clk = ~clk;

  // Reference model: behaviour expressed as elapsed time since qualify/hold start and last accepted strobe.
  int         m_edge = 0;
  int         m_state = 0;
  int         q_start = 0, h_start = 0;
  bit         m_rdy = 0;
  bit         w_live = 0, r_live = 0;
  int         w_edge = 0, r_edge = 0;
  int         m_cnt = 0;
  bit   [2:0] ch_h = '0, he_h = '0, se_h = '0;
  logic [LANES-1:0] lane_h [3];
  bit         ok, he_s, rise, prev_rdy;

  initial for (int i = 0; i < 3; i++) lane_h[i] = '0;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_state = 0; m_rdy = 0; w_live = 0; r_live = 0; m_cnt = 0;
      ch_h = '0; he_h = '0; se_h = '0;
      for (int i = 0; i < 3; i++) lane_h[i] = '0;
    end else begin
      ok       = ch_h[1] && (&lane_h[1]);
      he_s     = he_h[1];
      rise     = se_h[1] && !se_h[2];
      prev_rdy = m_rdy;
      case (m_state)
        0: if (ok) begin m_state = 1; q_start = m_edge; end
        1: if (he_s || !ok) m_state = 0;
           else if (m_edge - q_start == QUAL) m_state = 2;
        2: if (he_s) begin m_state = 3; h_start = m_edge; end
           else if (!ok) m_state = 0;
        default: if (he_s) h_start = m_edge;
                 else if (m_edge - h_start == HOLD) m_state = 0;
      endcase
      m_rdy = (m_state == 2);
      if (!prev_rdy) w_live = 0;
      else if (fifo_wr_en) begin w_live = 1; w_edge = m_edge; end
      if (!prev_rdy) r_live = 0;
      else if (fifo_rd_en) begin r_live = 1; r_edge = m_edge; end
`ifdef AURORA_SOFT_ERR_COUNT_EN
      if (err_clr) m_cnt = 0;
      else if (rise && m_cnt < ERR_MAX) m_cnt++;
`else
      m_cnt = 0;
`endif
      ch_h = {ch_h[1:0], channel_up};
      he_h = {he_h[1:0], hard_err};
      se_h = {se_h[1:0], soft_err};
      lane_h[2] = lane_h[1]; lane_h[1] = lane_h[0]; lane_h[0] = lane_up;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check("model_rdy", 32'(rdy), 32'(m_rdy));
    check("model_state", 32'(link_state), 32'(m_state));
    check("model_wr_act", 32'(wr_act), 32'(w_live && (m_edge - w_edge < STRETCH)));
    check("model_rd_act", 32'(rd_act), 32'(r_live && (m_edge - r_edge < STRETCH)));
    check("model_cnt", 32'(soft_err_cnt), 32'(m_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_output();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; channel_up = 1'b0; lane_up = '0; hard_err = 1'b0; soft_err = 1'b0;
    fifo_wr_en = 1'b0; fifo_rd_en = 1'b0; err_clr = 1'b0;
    run(1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst; logic ch; logic [1:0] lane; logic wr; logic rd;
    logic [1:0] st; logic rdy; logic wa; logic ra;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic c, input logic [1:0] l, input logic w,
                         input logic d, input logic [1:0] s, input logic y, input logic wa,
                         input logic ra);
    vec_t v;
    v.rst = r; v.ch = c; v.lane = l; v.wr = w; v.rd = d;
    v.st = s; v.rdy = y; v.wa = wa; v.ra = ra;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; channel_up = vecs[i].ch; lane_up = vecs[i].lane;
      fifo_wr_en = vecs[i].wr; fifo_rd_en = vecs[i].rd;
      hard_err = 1'b0; soft_err = 1'b0; err_clr = 1'b0;
      run(1);
      check($sformatf("vec%0d_state", i), 32'(link_state), 32'(vecs[i].st));
      check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_wr_act", i), 32'(wr_act), 32'(vecs[i].wa));
      check($sformatf("vec%0d_rd_act", i), 32'(rd_act), 32'(vecs[i].ra));
      check($sformatf("vec%0d_cnt", i), 32'(soft_err_cnt), 32'd0);
    end
  endtask

  int hold_len;

  initial begin
    run(2);
    // Bring-up from reset, gated strobe, single stretches, then link loss mid-stretch.
    add_vec(1, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0);
    add_vec(0, 1, 2'b11, 0, 0, 2'd0, 0, 0, 0);
    add_vec(0, 1, 2'b11, 0, 0, 2'd0, 0, 0, 0);
    add_vec(0, 1, 2'b11, 0, 0, 2'd1, 0, 0, 0);
    add_vec(0, 1, 2'b11, 1, 0, 2'd1, 0, 0, 0);
    for (int i = 0; i < 6; i++) add_vec(0, 1, 2'b11, 0, 0, 2'd1, 0, 0, 0);
    add_vec(0, 1, 2'b11, 0, 0, 2'd2, 1, 0, 0);
    add_vec(0, 1, 2'b11, 1, 0, 2'd2, 1, 1, 0);
    add_vec(0, 1, 2'b11, 0, 1, 2'd2, 1, 1, 1);
    add_vec(0, 1, 2'b11, 0, 0, 2'd2, 1, 1, 1);
    add_vec(0, 1, 2'b11, 0, 0, 2'd2, 1, 1, 1);
    add_vec(0, 1, 2'b11, 0, 0, 2'd2, 1, 0, 1);
    add_vec(0, 1, 2'b11, 0, 0, 2'd2, 1, 0, 0);
    add_vec(0, 0, 2'b11, 1, 1, 2'd2, 1, 1, 1);
    add_vec(0, 0, 2'b11, 0, 0, 2'd2, 1, 1, 1);
    add_vec(0, 0, 2'b11, 0, 0, 2'd0, 0, 1, 1);
    add_vec(0, 0, 2'b11, 0, 0, 2'd0, 0, 0, 0);
    apply_stimulus();

    // One-cycle lane drop during qualification forces a full requalification.
    do_reset();
    channel_up = 1'b1; lane_up = 2'b11;
    run(5);
    lane_up = 2'b01;
    run(1);
    lane_up = 2'b11;
    run(2);
    check("drop_state", 32'(link_state), 32'd0);
    run(8);
    check("requal_not_yet", 32'(rdy), 32'd0);
    run(1);
    check("requal_rdy", 32'(rdy), 32'd1);

    // Hard error pulse: sixteen cycles of hold-off, then requalification.
    hard_err = 1'b1;
    run(1);
    hard_err = 1'b0;
    run(2);
    check("hold_entry", 32'(link_state), 32'd3);
    check("hold_rdy", 32'(rdy), 32'd0);
    hold_len = 1;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (link_state != 2'd3) break;
      hold_len++;
    end
    check("hold_length", 32'(hold_len), 32'(HOLD));
    check("hold_exit", 32'(link_state), 32'd0);
    run(8);
    check("post_hold_not_yet", 32'(rdy), 32'd0);
    run(1);
    check("post_hold_rdy", 32'(rdy), 32'd1);

    // Retriggered write strobes three cycles apart keep wr_act continuously high.
    for (int i = 0; i < 10; i++) begin
      fifo_wr_en = (i % 3 == 0) && (i <= 6);
      run(1);
      check("retrigger_wr", 32'(wr_act), 32'd1);
      check("retrigger_rd", 32'(rd_act), 32'd0);
    end
    fifo_wr_en = 1'b0;
    run(1);
    check("retrigger_end", 32'(wr_act), 32'd0);

    // Twenty soft-error pulses, then a clear that coincides with a counted edge.
    for (int i = 0; i < 20; i++) begin
      soft_err = 1'b1;
      run(1);
      soft_err = 1'b0;
      run(1);
    end
    run(3);
`ifdef AURORA_SOFT_ERR_COUNT_EN
    check("soft_saturate", 32'(soft_err_cnt), 32'(ERR_MAX));
`else
    check("soft_disabled", 32'(soft_err_cnt), 32'd0);
`endif
    soft_err = 1'b1;
    run(1);
    soft_err = 1'b0;
    run(1);
    err_clr = 1'b1;
    run(1);
    err_clr = 1'b0;
    check("soft_clear", 32'(soft_err_cnt), 32'd0);
    run(3);
    check("soft_clear_hold", 32'(soft_err_cnt), 32'd0);

    // Randomised traffic with occasional link faults and resets.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 699) == 0);
      channel_up = ($urandom_range(0, 99) < 99);
      lane_up    = ($urandom_range(0, 99) < 98) ? 2'b11 : 2'($urandom_range(0, 3));
      hard_err   = ($urandom_range(0, 299) == 0);
      soft_err   = ($urandom_range(0, 3) == 0);
      fifo_wr_en = ($urandom_range(0, 2) == 0);
      fifo_rd_en = ($urandom_range(0, 4) == 0);
      err_clr    = ($urandom_range(0, 49) == 0);
      run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
